// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the instruction-fetch stage's external signals:
//     - instruction memory request/ready handshake (mem_req, mem_addr,
//       mem_ready, mem_rdata)
//     - held instruction towards decode/immgen (instr, instr_pc,
//       instr_valid, instr_ack)
//     - control-flow redirect from the branch/jump unit (redirect,
//       redirect_pc)
//   master : the fetch stage itself
//   slave  : everything around it (memory, decode, branch unit)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ack;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ready, mem_rdata, instr_ack, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ready, mem_rdata, instr_ack, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Issues one fetch at a time to instruction
//   memory, holds the returned word and its PC until decode acknowledges it,
//   and follows redirects from the branch/jump unit. A redirect that arrives
//   while a memory request is still outstanding cannot cancel that request,
//   so the stage waits it out in FLUSH and drops the returned data.
//
//   Ports:
//     clk  - core clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - instr_fetch_if.master (memory handshake, held instruction,
//            redirect inputs)
//   Parameter:
//     RESET_PC - first fetch address after reset, word aligned
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD,
    FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;

  // Redirect targets are always word aligned; the low two bits are dropped.
  logic [31:0] redirect_tgt;
  assign redirect_tgt = bus.redirect_pc & ~32'h3;

  // NOTE: every variable assigned here gets its hold value first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (bus.redirect) pc_d = redirect_tgt;
      end

      REQ: begin
        if (bus.mem_ready && !bus.redirect) begin
          instr_d    = bus.mem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end else if (bus.mem_ready && bus.redirect) begin
          // Data belongs to the abandoned stream; refetch at the target.
          pc_d = redirect_tgt;
        end else if (bus.redirect) begin
          // Request in flight cannot be withdrawn: remember where to go.
          target_d = redirect_tgt;
          state_d  = FLUSH;
        end
      end

      FLUSH: begin
        if (bus.redirect) target_d = redirect_tgt;
        if (bus.mem_ready) begin
          // A redirect landing with the final beat beats the stored target.
          pc_d    = bus.redirect ? redirect_tgt : target_q;
          state_d = REQ;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (bus.instr_ack) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      target_q   <= 32'h0;
      instr_q    <= NOP;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.mem_req     = (state_q == REQ) || (state_q == FLUSH);
  assign bus.mem_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. Directed scenarios check fixed
//   expected values; a randomized run compares every output each cycle
//   against a flag-based reference model (booting / holding / stale request
//   outstanding) of the fetch rules. A second instance with RESET_PC at the
//   top of the address space checks PC wrap-around.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic        m_boot, m_hold, m_stale;
  logic [31:0] m_pc, m_tgt, m_instr, m_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h0000_5A13;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_hold = 1'b0; m_stale = 1'b0;
    m_pc = 32'h0; m_tgt = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
  endtask

  // Applies one clock edge of the fetch rules to the model.
  task automatic model_update(input logic rdy, input logic ack, input logic redir,
                              input logic [31:0] rpc, input logic [31:0] rdata);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (m_boot) begin
      m_boot = 1'b0;
      if (redir) m_pc = tgt;
    end else if (m_hold) begin
      if (redir) begin m_pc = tgt; m_hold = 1'b0; end
      else if (ack) begin m_pc = m_pc + 32'd4; m_hold = 1'b0; end
    end else if (rdy) begin
      if (m_stale) begin m_pc = redir ? tgt : m_tgt; m_stale = 1'b0; end
      else if (redir) m_pc = tgt;
      else begin m_instr = rdata; m_ipc = m_pc; m_hold = 1'b1; end
    end else if (redir) begin
      m_tgt = tgt;
      m_stale = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; drives inputs, crosses one rising edge,
  // advances the model and returns at the next falling edge.
  task automatic step(input logic rdy, input logic ack, input logic redir,
                      input logic [31:0] rpc, input logic [31:0] rdata);
    bus.mem_ready   = rdy;
    bus.mem_rdata   = rdy ? rdata : 32'hDEAD_BEEF;
    bus.instr_ack   = ack;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    @(posedge clk);
    model_update(rdy, ack, redir, rpc, rdata);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0; bus.instr_ack = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus2.mem_ready = 1'b0; bus2.mem_rdata = 32'h0; bus2.instr_ack = 1'b0;
    bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", bus.instr); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    do_reset();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL boot_mem_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL zw_first_req: got %b want 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_first_addr: got %h want 0", bus.mem_addr); end
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0010_0093);
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b want 1", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0010_0093) begin n_fail++; $display("FAIL zw_instr: got %h want 00100093", bus.instr); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL zw_instr_pc: got %h want 0", bus.instr_pc); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL zw_hold_req: got %b want 0", bus.mem_req); end
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.mem_addr !== 32'h4) begin n_fail++; $display("FAIL zw_next_addr: got %h want 4", bus.mem_addr); end
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL zw_next_req: got %b want 1", bus.mem_req); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_ack_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0010_0093) begin n_fail++; $display("FAIL zw_instr_kept: got %h want 00100093", bus.instr); end
  endtask

  task automatic test_wait_hold();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
        n_fail++; $display("FAIL wait_req_stable[%0d]: got req=%b addr=%h want req=1 addr=0", i, bus.mem_req, bus.mem_addr);
      end
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid_early[%0d]: got %b want 0", i, bus.instr_valid); end
      step(i == 3, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1234_5678 || bus.mem_req !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got valid=%b instr=%h req=%b want 1/12345678/0", i, bus.instr_valid, bus.instr, bus.mem_req);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_before_ack: got %b want 1", bus.instr_valid); end
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.mem_addr !== 32'h4 || bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL wait_after_ack: got req=%b addr=%h want req=1 addr=4", bus.mem_req, bus.mem_addr);
    end
  endtask

  // Continues from test_wait_hold: REQ at address 4.
  task automatic test_redirect_hold();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0513);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4) begin
      n_fail++; $display("FAIL rh_capture: got valid=%b pc=%h want 1/4", bus.instr_valid, bus.instr_pc);
    end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0);
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rh_addr: got %h want 00000100", bus.mem_addr); end
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rh_req: got %b want 1", bus.mem_req); end
  endtask

  // Continues from test_redirect_hold: REQ at 0x100, two wait cycles left.
  task automatic test_flush();
    step(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL fl_hold_old1: got req=%b addr=%h want 1/100", bus.mem_req, bus.mem_addr);
    end
    step(1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL fl_hold_old2: got req=%b addr=%h valid=%b want 1/100/0", bus.mem_req, bus.mem_addr, bus.instr_valid);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0BAD_0BAD);
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fl_discard: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.mem_addr !== 32'h300 || bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL fl_latest_target: got req=%b addr=%h want 1/300", bus.mem_req, bus.mem_addr);
    end
    n_checks++; if (bus.instr === 32'h0BAD_0BAD) begin n_fail++; $display("FAIL fl_instr_overwritten: got %h want not 0bad0bad", bus.instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus2.mem_ready = 1'b1; bus2.mem_rdata = 32'h0000_0513; bus2.instr_ack = 1'b1;
    n_checks++; if (bus2.mem_addr !== 32'hFFFF_FFFC || bus2.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL wrap_boot: got req=%b addr=%h want 0/fffffffc", bus2.mem_req, bus2.mem_addr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus2.mem_addr !== 32'hFFFF_FFFC || bus2.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", bus2.mem_req, bus2.mem_addr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 32'hFFFF_FFFC || bus2.instr !== 32'h0000_0513) begin
      n_fail++; $display("FAIL wrap_capture: got valid=%b pc=%h instr=%h want 1/fffffffc/00000513", bus2.instr_valid, bus2.instr_pc, bus2.instr);
    end
    bus2.mem_ready = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus2.mem_addr !== 32'h0000_0000 || bus2.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_next_addr: got req=%b addr=%h want 1/00000000", bus2.mem_req, bus2.mem_addr);
    end
    bus2.instr_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0093);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin
      n_fail++; $display("FAIL ar_in_flush: got req=%b addr=%h want 1/4", bus.mem_req, bus.mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req_async: got %b want 0", bus.mem_req); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_async: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.mem_addr !== 32'h0 || bus.instr !== 32'h0000_0013) begin
      n_fail++; $display("FAIL ar_values_async: got addr=%h instr=%h want 0/00000013", bus.mem_addr, bus.instr);
    end
    do_reset();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_boot_req: got %b want 0", bus.mem_req); end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL ar_restart: got req=%b addr=%h want 1/0", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_random();
    logic        rdy, ack, redir;
    logic [31:0] rpc;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      n_checks++; if (bus.mem_req !== (!m_boot && !m_hold)) begin
        n_fail++; $display("FAIL rnd_mem_req @%0d: got %b want %b", cyc, bus.mem_req, !m_boot && !m_hold);
      end
      n_checks++; if (bus.mem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_mem_addr @%0d: got %h want %h", cyc, bus.mem_addr, m_pc); end
      n_checks++; if (bus.instr_valid !== m_hold) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, bus.instr_valid, m_hold); end
      n_checks++; if (bus.instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr @%0d: got %h want %h", cyc, bus.instr, m_instr); end
      n_checks++; if (bus.instr_pc !== m_ipc) begin n_fail++; $display("FAIL rnd_instr_pc @%0d: got %h want %h", cyc, bus.instr_pc, m_ipc); end
      rdy   = ($urandom_range(0, 2) == 0);
      ack   = ($urandom_range(0, 1) == 0);
      redir = ($urandom_range(0, 5) == 0);
      rpc   = $urandom;
      step(rdy, ack, redir, rpc, mem_word(m_pc));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_hold();
    test_redirect_hold();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
